// File: rtl/spi_byte_engine.sv
// spi_byte_engine: SPI mode-0 master that shifts one byte out on MOSI and one in from MISO per request
module spi_byte_engine #(
    parameter int HALF_PERIOD = 4,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       getByte,
    input  logic [7:0] sndData,
    input  logic       MISO,
    output logic       BUSY,
    output logic [7:0] RxData,
    output logic       SCLK,
    output logic       MOSI
);
    typedef enum logic [1:0] {IDLE, SETUP, HIGH} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0] bits, bits_nx;
    logic [6:0] tx, tx_nx;
    logic [7:0] rx, rx_nx, rx_data_nx;
    logic busy_nx, sclk_nx, mosi_nx;
    // The accepting edge loads the byte and counts as the first SCLK-low cycle, so BUSY spans 16 half-periods
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bits_nx    = bits;
        tx_nx      = tx;
        rx_nx      = rx;
        rx_data_nx = RxData;
        busy_nx    = BUSY;
        sclk_nx    = SCLK;
        mosi_nx    = MOSI;
        case (state)
            IDLE: if (getByte) begin
                state_nx = SETUP;
                tx_nx    = sndData[6:0];
                mosi_nx  = sndData[7];
                busy_nx  = 1'b1;
                cnt_nx   = '0;
                bits_nx  = '0;
            end
            SETUP: if (cnt == LAST) begin
                cnt_nx   = '0;
                sclk_nx  = 1'b1;
                rx_nx    = {rx[6:0], MISO};
                state_nx = HIGH;
            end else cnt_nx = cnt + 1'b1;
            HIGH: if (cnt == LAST) begin
                cnt_nx  = '0;
                sclk_nx = 1'b0;
                if (bits == 3'd7) begin
                    mosi_nx    = 1'b0;
                    rx_data_nx = rx;
                    busy_nx    = 1'b0;
                    state_nx   = IDLE;
                end else begin
                    tx_nx    = {tx[5:0], 1'b0};
                    mosi_nx  = tx[6];
                    bits_nx  = bits + 3'd1;
                    state_nx = SETUP;
                end
            end else cnt_nx = cnt + 1'b1;
            default: state_nx = IDLE;
        endcase
    end
    // All state and outputs are registered; reset drops everything at once, discarding any partial byte
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            bits   <= '0;
            tx     <= '0;
            rx     <= '0;
            RxData <= '0;
            BUSY   <= 1'b0;
            SCLK   <= 1'b0;
            MOSI   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            bits   <= bits_nx;
            tx     <= tx_nx;
            rx     <= rx_nx;
            RxData <= rx_data_nx;
            BUSY   <= busy_nx;
            SCLK   <= sclk_nx;
            MOSI   <= mosi_nx;
        end
    end
endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine: directed scoreboard bench for two engines (HALF_PERIOD 2 and 1)
module tb_spi_byte_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] get_b = 2'b00;
    logic [1:0] busy, sclk, mosi;
    logic [7:0] snd [2];
    logic [7:0] rxd [2];
    logic miso0, sl_load = 1'b0;
    logic [7:0] slave_tx, slave_rx;
    logic [7:0] q [$];
    int mode = 0;
    int compared = 0;
    int mismatched = 0;
    int rises;
    logic ps;

    always #5 clk = ~clk;

    assign miso0 = (mode == 0) ? mosi[0] : (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : slave_tx[7];

    // Mode-0 slave: presents its byte MSB first, advancing on SCLK fall, capturing MOSI on SCLK rise
    always @(negedge sclk[0] or posedge sl_load)
        if (sl_load) slave_tx <= 8'h3C;
        else slave_tx <= {slave_tx[6:0], 1'b0};
    always @(posedge sclk[0]) slave_rx <= {slave_rx[6:0], mosi[0]};

    spi_byte_engine #(.HALF_PERIOD(2), .CNT_W(8)) dut0 (
        .CLK(clk), .RST(rst_n), .getByte(get_b[0]), .sndData(snd[0]), .MISO(miso0),
        .BUSY(busy[0]), .RxData(rxd[0]), .SCLK(sclk[0]), .MOSI(mosi[0]));
    spi_byte_engine #(.HALF_PERIOD(1), .CNT_W(8)) dut1 (
        .CLK(clk), .RST(rst_n), .getByte(get_b[1]), .sndData(snd[1]), .MISO(mosi[1]),
        .BUSY(busy[1]), .RxData(rxd[1]), .SCLK(sclk[1]), .MOSI(mosi[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input int i, input int hp, input logic [7:0] d, input logic [7:0] exp, input bit keep);
        int n, r, bad;
        logic [7:0] mo, r0;
        logic p_s, p_m;
        q.push_back(exp);
        snd[i] = d;
        get_b[i] = 1'b1;
        r0 = rxd[i];
        @(negedge clk);
        chk("busy_rise", 32'(busy[i]), 32'd1);
        chk("mosi_msb", 32'(mosi[i]), 32'(d[7]));
        if (keep) snd[i] = ~d;
        else get_b[i] = 1'b0;
        n = 1; r = 0; bad = 0; mo = '0;
        p_s = sclk[i]; p_m = mosi[i];
        while (busy[i] && n <= 40 * hp) begin
            @(negedge clk);
            if (busy[i]) n++;
            if (sclk[i] && !p_s) begin
                r++;
                mo = {mo[6:0], mosi[i]};
            end
            if (mosi[i] !== p_m && !(p_s && !sclk[i])) bad++;
            if (busy[i] && rxd[i] !== r0) bad++;
            p_s = sclk[i]; p_m = mosi[i];
        end
        chk("busy_len", 32'(n), 32'(16 * hp));
        chk("sclk_rises", 32'(r), 32'd8);
        chk("mosi_bits", 32'(mo), 32'(d));
        chk("mode0_stable", 32'(bad), 32'd0);
        chk("rx_data", 32'(rxd[i]), 32'(q.pop_front()));
        chk("idle_lines", 32'({sclk[i], mosi[i]}), 32'd0);
    endtask

    initial begin
        snd[0] = 8'h00;
        snd[1] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({busy[0], sclk[0], mosi[0]}), 32'd0);
        chk("reset_rx", 32'(rxd[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 0; xfer(0, 2, 8'hA5, 8'hA5, 1'b0);
        mode = 1; xfer(0, 2, 8'h00, 8'hFF, 1'b0);
        mode = 2; xfer(0, 2, 8'hFF, 8'h00, 1'b0);
        mode = 3; sl_load = 1'b1; #1 sl_load = 1'b0;
        @(negedge clk);
        xfer(0, 2, 8'hC3, 8'h3C, 1'b0);
        chk("slave_rx", 32'(slave_rx), 32'hC3);
        mode = 0;
        xfer(0, 2, 8'h01, 8'h01, 1'b1);
        xfer(0, 2, 8'h80, 8'h80, 1'b1);
        xfer(0, 2, 8'h5A, 8'h5A, 1'b0);
        xfer(0, 2, 8'h77, 8'h77, 1'b0);
        snd[0] = 8'hFF;
        get_b[0] = 1'b1;
        @(negedge clk);
        get_b[0] = 1'b0;
        rises = 0;
        ps = sclk[0];
        for (int k = 0; k < 100 && rises < 5; k++) begin
            @(negedge clk);
            if (sclk[0] && !ps) rises++;
            ps = sclk[0];
        end
        chk("pre_rst_lines", 32'({busy[0], sclk[0], mosi[0]}), 32'd7);
        chk("pre_rst_rx", 32'(rxd[0]), 32'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_lines", 32'({busy[0], sclk[0], mosi[0]}), 32'd0);
        chk("async_rst_rx", 32'(rxd[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(0, 2, 8'hE7, 8'hE7, 1'b0);
        xfer(1, 1, 8'h96, 8'h96, 1'b0);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
